// File: rtl/difftest_commit_serializer_if.sv
// Commit-bundle ingress and single-beat trace egress bundled as one port.
// slave = serializer side, master = commit stage + trace sink side.
interface difftest_commit_serializer_if #(
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_DW             = 64,
  parameter int CONFIG_PC_W           = 62,
  parameter int CONFIG_INSN_DW        = 32,
  parameter int CONFIG_LRF_AW         = 5
);
  localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH;

  logic [CW-1:0]                in_valid;
  logic [CONFIG_PC_W*CW-1:0]    in_pc;
  logic [CONFIG_INSN_DW*CW-1:0] in_ins;
  logic [CW-1:0]                in_wen;
  logic [CONFIG_LRF_AW*CW-1:0]  in_wnum;
  logic [CONFIG_DW*CW-1:0]      in_wdat;
  logic                         in_excp;
  logic [7:0]                   in_excp_vect;
  logic                         in_ready;

  logic                         out_valid;
  logic                         out_ready;
  logic                         out_kind;
  logic [CONFIG_PC_W-1:0]       out_pc;
  logic [CONFIG_INSN_DW-1:0]    out_ins;
  logic                         out_wen;
  logic [CONFIG_LRF_AW-1:0]     out_wnum;
  logic [CONFIG_DW-1:0]         out_wdat;
  logic [7:0]                   out_excp_vect;
  logic                         out_last;
  logic [31:0]                  out_cycle;
  logic                         overflow;

  modport slave (
    input  in_valid, in_pc, in_ins, in_wen, in_wnum,
    input  in_wdat, in_excp, in_excp_vect, out_ready,
    output in_ready, out_valid, out_kind, out_pc,
    output out_ins, out_wen, out_wnum, out_wdat,
    output out_excp_vect, out_last, out_cycle, overflow
  );

  modport master (
    output in_valid, in_pc, in_ins, in_wen, in_wnum,
    output in_wdat, in_excp, in_excp_vect, out_ready,
    input  in_ready, out_valid, out_kind, out_pc,
    input  out_ins, out_wen, out_wnum, out_wdat,
    input  out_excp_vect, out_last, out_cycle, overflow
  );
endinterface

// File: rtl/difftest_commit_serializer.sv
// Buffers multi-lane commit bundles in a FIFO and drains them one beat
// at a time in lane order, exception beat last.
// Ports: clk, rst (sync, active high), bus (slave modport): in_* bundle
// push with in_ready, out_* beat stream with out_ready, sticky overflow.
// Option: DIFFTEST_SERIAL_CYCLE_STAMP_EN stamps each bundle with a cycle
// count shown on out_cycle; otherwise out_cycle is 0.
module difftest_commit_serializer #(
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_DW             = 64,
  parameter int CONFIG_PC_W           = 62,
  parameter int CONFIG_INSN_DW        = 32,
  parameter int CONFIG_LRF_AW         = 5,
  parameter int CONFIG_P_FIFO_DEPTH   = 2
) (
  input logic                             clk,
  input logic                             rst,
  difftest_commit_serializer_if.slave     bus
);
  localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int DEPTH = 1 << CONFIG_P_FIFO_DEPTH;
  localparam int LPW   = CONFIG_P_COMMIT_WIDTH + 1;
  localparam int FAW   = CONFIG_P_FIFO_DEPTH;
  localparam int PCW   = CONFIG_PC_W;
  localparam int IW    = CONFIG_INSN_DW;
  localparam int RW    = CONFIG_LRF_AW;
  localparam int DW    = CONFIG_DW;

  typedef logic [LPW-1:0] lane_t;
  typedef logic [FAW:0]   ptr_t;
  typedef logic [FAW-1:0] idx_t;

  typedef struct packed {
    logic [CW-1:0]     valid;
    logic [PCW*CW-1:0] pc;
    logic [IW*CW-1:0]  ins;
    logic [CW-1:0]     wen;
    logic [RW*CW-1:0]  wnum;
    logic [DW*CW-1:0]  wdat;
    logic              excp;
    logic [7:0]        vect;
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
    logic [31:0]       cyc;
`endif
  } entry_t;

  typedef struct packed {
    logic           kind;
    logic           last;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ins;
    logic           wen;
    logic [RW-1:0]  wnum;
    logic [DW-1:0]  wdat;
    logic [7:0]     vect;
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
    logic [31:0]    cyc;
`endif
  } beat_t;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  // Lowest valid lane at or above 'from'; CW means none left.
  function automatic lane_t nxt(
    input logic [CW-1:0] v,
    input lane_t         from
  );
    lane_t r;
    r = lane_t'(CW);
    for (int i = CW - 1; i >= 0; i--)
      if (v[i] && (i >= int'(from)))
        r = lane_t'(i);
    return r;
  endfunction

  // Lane index CW selects the exception beat.
  function automatic beat_t mk_beat(
    input entry_t e,
    input lane_t  l
  );
    beat_t b;
    int    k;
    b = '0;
    k = int'(l);
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
    b.cyc = e.cyc;
`endif
    if (k >= CW) begin
      b.kind = 1'b1;
      b.last = 1'b1;
      b.vect = e.vect;
    end else begin
      b.pc   = e.pc[k*PCW +: PCW];
      b.ins  = e.ins[k*IW +: IW];
      b.wen  = e.wen[k +: 1];
      b.wnum = e.wnum[k*RW +: RW];
      b.wdat = e.wdat[k*DW +: DW];
      b.last = (nxt(e.valid, l + lane_t'(1)) == lane_t'(CW))
             && !e.excp;
    end
    return b;
  endfunction

  entry_t mem [DEPTH];
  ptr_t   wptr, rptr, cnt;
  state_t state;
  lane_t  lane_ptr;
  beat_t  beat;
  logic   ov, ovf;
  logic   push, wr, full, empty;
  entry_t in_e, cur_e, ld_e;
  logic   ld_ok;
  lane_t  ld_lane, step_lane;
  idx_t   nidx;

`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
  logic [31:0] cyc_q;
`endif

  assign push  = (|bus.in_valid) | bus.in_excp;
  assign empty = (wptr == rptr);
  assign full  = (wptr[FAW] != rptr[FAW])
              && (wptr[FAW-1:0] == rptr[FAW-1:0]);
  assign wr    = push && !full;
  assign cnt   = wptr - rptr;
  assign nidx  = rptr[FAW-1:0] + idx_t'(1);

  always_comb begin
    in_e       = '0;
    in_e.valid = bus.in_valid;
    in_e.pc    = bus.in_pc;
    in_e.ins   = bus.in_ins;
    in_e.wen   = bus.in_wen;
    in_e.wnum  = bus.in_wnum;
    in_e.wdat  = bus.in_wdat;
    in_e.excp  = bus.in_excp;
    in_e.vect  = bus.in_excp_vect;
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
    in_e.cyc   = cyc_q;
`endif
  end

  // The next bundle comes from the FIFO when one is queued behind the
  // head; otherwise it is taken straight from this cycle's push so a
  // bundle can appear the cycle after it arrives.
  always_comb begin
    cur_e = mem[rptr[FAW-1:0]];
    if (state == S_IDLE) begin
      ld_ok = !empty || wr;
      ld_e  = empty ? in_e : cur_e;
    end else begin
      ld_ok = (cnt > ptr_t'(1)) || wr;
      ld_e  = (cnt > ptr_t'(1)) ? mem[nidx] : in_e;
    end
    ld_lane   = nxt(ld_e.valid, lane_t'(0));
    step_lane = nxt(cur_e.valid, lane_ptr + lane_t'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst && wr)
      mem[wptr[FAW-1:0]] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      lane_ptr <= '0;
      ov       <= 1'b0;
      ovf      <= 1'b0;
      beat     <= '0;
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
      cyc_q    <= '0;
`endif
    end else begin
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
      cyc_q <= cyc_q + 32'd1;
`endif
      if (wr)
        wptr <= wptr + ptr_t'(1);
      if (push && full)
        ovf <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (ld_ok) begin
            state    <= S_DRAIN;
            ov       <= 1'b1;
            lane_ptr <= ld_lane;
            beat     <= mk_beat(ld_e, ld_lane);
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (beat.last) begin
              rptr <= rptr + ptr_t'(1);
              if (ld_ok) begin
                lane_ptr <= ld_lane;
                beat     <= mk_beat(ld_e, ld_lane);
              end else begin
                state    <= S_IDLE;
                ov       <= 1'b0;
                lane_ptr <= '0;
                beat     <= '0;
              end
            end else begin
              lane_ptr <= step_lane;
              beat     <= mk_beat(cur_e, step_lane);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = !full;
  assign bus.out_valid     = ov;
  assign bus.out_kind      = beat.kind;
  assign bus.out_last      = beat.last;
  assign bus.out_pc        = beat.pc;
  assign bus.out_ins       = beat.ins;
  assign bus.out_wen       = beat.wen;
  assign bus.out_wnum      = beat.wnum;
  assign bus.out_wdat      = beat.wdat;
  assign bus.out_excp_vect = beat.vect;
  assign bus.overflow      = ovf;
`ifdef DIFFTEST_SERIAL_CYCLE_STAMP_EN
  assign bus.out_cycle     = beat.cyc;
`else
  assign bus.out_cycle     = 32'd0;
`endif
endmodule
